// File: rtl/pll_seq_pkg.sv
// Shared types and width helpers for the PLL reset sequencer.
//   pll_seq_state_e : FSM state encoding, also exported on the debug state port
//   clog2 / max_u   : elaboration-time helpers for counter widths
package pll_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4,
        FAIL      = 3'd5
    } pll_seq_state_e;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (longint unsigned p = 1; p < longint'(v); p = p << 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchroniser for a single asynchronous level, synchronous reset.
//   clk : destination clock
//   rst : synchronous active-high reset, clears both stages
//   d   : asynchronous input
//   q   : synchronised output (2 cycles of latency)
module bit_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL supervisor: resets the PLL, waits for lock with timeout and retries,
// qualifies lock, then releases channel resets one at a time.
//   refclk     : PLL reference clock, sole clock
//   rst        : synchronous active-high reset
//   pll_locked : asynchronous PLL lock
//   retry_req  : pulse, restarts from FAIL
//   pll_rst    : PLL reset (active-high)
//   chan_rst   : per-channel resets, bit 0 released first
//   ready      : all channels released and lock held
//   fail       : lock attempts exhausted
//   loss_count : saturating lock-loss count
//   state      : FSM state (debug)
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS        = 4,
    parameter int unsigned PLL_RST_CYCLES      = 16,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned STAGE_GAP_CYCLES    = 8,
    parameter int unsigned MAX_RETRIES         = 3,
    parameter int unsigned LOSS_CNT_W          = 8
) (
    input  logic                    refclk,
    input  logic                    rst,
    input  logic                    pll_locked,
    input  logic                    retry_req,
    output logic                    pll_rst,
    output logic [NUM_CHANNELS-1:0] chan_rst,
    output logic                    ready,
    output logic                    fail,
    output logic [LOSS_CNT_W-1:0]   loss_count,
    output logic [2:0]              state
);

    localparam int unsigned CNT_MAX = max_u(max_u(LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES),
                                            max_u(PLL_RST_CYCLES, STAGE_GAP_CYCLES * NUM_CHANNELS));
    localparam int unsigned CNT_W   = clog2(CNT_MAX) + 1;
    localparam int unsigned RTY_W   = max_u(1, clog2(MAX_RETRIES + 1));

    localparam logic [NUM_CHANNELS-1:0] CHAN_ALL = '1;
    localparam logic [LOSS_CNT_W-1:0]   LOSS_MAX = '1;

    pll_seq_state_e          state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [RTY_W-1:0]        retry_q, retry_d;
    logic [LOSS_CNT_W-1:0]   loss_q, loss_d;
    logic [NUM_CHANNELS-1:0] chan_rst_q, chan_rst_d;
    logic                    pll_rst_q, pll_rst_d;
    logic                    ready_q, ready_d;
    logic                    fail_q, fail_d;
    logic                    lk_s;

    bit_sync u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lk_s)
    );

    // State and registered outputs.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q    <= PLL_RST;
            cnt_q      <= '0;
            retry_q    <= '0;
            loss_q     <= '0;
            chan_rst_q <= CHAN_ALL;
            pll_rst_q  <= 1'b1;
            ready_q    <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            retry_q    <= retry_d;
            loss_q     <= loss_d;
            chan_rst_q <= chan_rst_d;
            pll_rst_q  <= pll_rst_d;
            ready_q    <= ready_d;
            fail_q     <= fail_d;
        end
    end

    // Next state; outputs are derived from the next state so they land on the same edge.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        retry_d    = retry_q;
        loss_d     = loss_q;
        chan_rst_d = chan_rst_q;

        unique case (state_q)
            PLL_RST: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(PLL_RST_CYCLES - 1)) state_d = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Lock beats a coincident timeout.
                if (lk_s) begin
                    state_d = STABLE;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
                    retry_d = retry_q + RTY_W'(1);
                    state_d = (retry_d == RTY_W'(MAX_RETRIES)) ? FAIL : PLL_RST;
                end
            end
            STABLE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!lk_s) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!lk_s) begin
                    state_d = PLL_RST;
                    if (loss_q != LOSS_MAX) loss_d = loss_q + LOSS_CNT_W'(1);
                end else if (cnt_q == CNT_W'(STAGE_GAP_CYCLES - 1)) begin
                    // Counter restarts per stage; shifting keeps chan_rst thermometer-coded.
                    cnt_d      = '0;
                    chan_rst_d = chan_rst_q << 1;
                    if (chan_rst_d == '0) begin
                        state_d = RUN;
                        retry_d = '0;
                    end
                end
            end
            RUN: begin
                if (!lk_s) begin
                    state_d = PLL_RST;
                    if (loss_q != LOSS_MAX) loss_d = loss_q + LOSS_CNT_W'(1);
                end
            end
            FAIL: begin
                if (retry_req) begin
                    retry_d = '0;
                    state_d = PLL_RST;
                end
            end
            default: state_d = PLL_RST;
        endcase

        if (state_d != state_q) cnt_d = '0;

        // Bit 0 drops on RELEASE entry; outside RELEASE/RUN every channel is held.
        if (state_d == RELEASE && state_q != RELEASE) begin
            chan_rst_d = CHAN_ALL << 1;
        end else if (state_d != RELEASE && state_d != RUN) begin
            chan_rst_d = CHAN_ALL;
        end

        pll_rst_d = (state_d == PLL_RST) || (state_d == FAIL);
        ready_d   = (state_d == RUN);
        fail_d    = (state_d == FAIL);
    end

    assign pll_rst    = pll_rst_q;
    assign chan_rst   = chan_rst_q;
    assign ready      = ready_q;
    assign fail       = fail_q;
    assign loss_count = loss_q;
    assign state      = state_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: directed scenarios plus random
// lock/retry/reset traffic, compared every cycle against a phase/elapsed-time model.
module tb_pll_reset_sequencer;

    localparam int NCH   = 3;
    localparam int PRSTC = 4;
    localparam int TOC   = 20;
    localparam int STBC  = 8;
    localparam int GAP   = 2;
    localparam int MAXR  = 2;
    localparam int LW    = 2;
    localparam int LMAX  = (1 << LW) - 1;

    localparam int P_PRST = 0;
    localparam int P_WAIT = 1;
    localparam int P_STAB = 2;
    localparam int P_REL  = 3;
    localparam int P_RUN  = 4;
    localparam int P_FAIL = 5;

    logic           refclk;
    logic           rst_i;
    logic           lock_i;
    logic           retry_i;
    logic           pll_rst;
    logic [NCH-1:0] chan_rst;
    logic           ready;
    logic           fail;
    logic [LW-1:0]  loss_count;
    logic [2:0]     state;

    int checks;
    int errors;

    pll_reset_sequencer #(
        .NUM_CHANNELS        (NCH),
        .PLL_RST_CYCLES      (PRSTC),
        .LOCK_TIMEOUT_CYCLES (TOC),
        .LOCK_STABLE_CYCLES  (STBC),
        .STAGE_GAP_CYCLES    (GAP),
        .MAX_RETRIES         (MAXR),
        .LOSS_CNT_W          (LW)
    ) dut (
        .refclk     (refclk),
        .rst        (rst_i),
        .pll_locked (lock_i),
        .retry_req  (retry_i),
        .pll_rst    (pll_rst),
        .chan_rst   (chan_rst),
        .ready      (ready),
        .fail       (fail),
        .loss_count (loss_count),
        .state      (state)
    );

    initial begin
        refclk = 1'b0;
        forever #5 refclk = ~refclk;
    end

    // Reference model: phase plus cycles elapsed in it; lock seen through a 2-deep delay line.
    int m_phase, m_el, m_retry, m_loss, m_nxt;
    bit m_lk;
    bit lkq[$];

    always @(posedge refclk) begin
        if (rst_i) begin
            m_phase = P_PRST;
            m_el    = 0;
            m_retry = 0;
            m_loss  = 0;
            lkq.delete();
            lkq.push_back(1'b0);
            lkq.push_back(1'b0);
        end else begin
            m_lk = lkq.pop_front();
            lkq.push_back(lock_i);
            m_nxt = m_phase;
            case (m_phase)
                P_PRST: if (m_el + 1 >= PRSTC) m_nxt = P_WAIT;
                P_WAIT: begin
                    if (m_lk) m_nxt = P_STAB;
                    else if (m_el + 1 >= TOC) begin
                        m_retry = m_retry + 1;
                        m_nxt = (m_retry >= MAXR) ? P_FAIL : P_PRST;
                    end
                end
                P_STAB: begin
                    if (!m_lk) m_nxt = P_WAIT;
                    else if (m_el + 1 >= STBC) m_nxt = P_REL;
                end
                P_REL: begin
                    if (!m_lk) begin
                        m_loss = (m_loss < LMAX) ? m_loss + 1 : LMAX;
                        m_nxt  = P_PRST;
                    end else if (m_el + 1 >= (NCH - 1) * GAP) begin
                        m_nxt   = P_RUN;
                        m_retry = 0;
                    end
                end
                P_RUN: begin
                    if (!m_lk) begin
                        m_loss = (m_loss < LMAX) ? m_loss + 1 : LMAX;
                        m_nxt  = P_PRST;
                    end
                end
                default: begin
                    if (retry_i) begin
                        m_retry = 0;
                        m_nxt   = P_PRST;
                    end
                end
            endcase
            m_el    = (m_nxt != m_phase) ? 0 : m_el + 1;
            m_phase = m_nxt;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        int all_ones;
        int rel;
        int exp_chan;
        all_ones = (1 << NCH) - 1;
        if (m_phase == P_REL) begin
            rel      = m_el / GAP + 1;
            exp_chan = all_ones & ~((1 << rel) - 1);
        end else if (m_phase == P_RUN) begin
            exp_chan = 0;
        end else begin
            exp_chan = all_ones;
        end
        check_eq("state",    32'(state),      32'(m_phase));
        check_eq("pll_rst",  32'(pll_rst),    32'((m_phase == P_PRST) || (m_phase == P_FAIL)));
        check_eq("chan_rst", 32'(chan_rst),   32'(exp_chan));
        check_eq("ready",    32'(ready),      32'(m_phase == P_RUN));
        check_eq("fail",     32'(fail),       32'(m_phase == P_FAIL));
        check_eq("loss",     32'(loss_count), 32'(m_loss));
    endtask

    task automatic cycle();
        @(negedge refclk);
        check_outputs();
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_state(input string tag, input int code, input int budget);
        int n;
        n = 0;
        while (32'(state) != 32'(code) && n < budget) begin
            cycle();
            n = n + 1;
        end
        check_eq(tag, 32'(state), 32'(code));
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        cycles(2);
        rst_i = 1'b0;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst_i   = 1'b1;
        lock_i  = 1'b0;
        retry_i = 1'b0;

        // Nominal bring-up with lock from cycle 10.
        do_reset();
        check_eq("rst_chan", 32'(chan_rst), 32'(3'b111));
        cycles(8);
        lock_i = 1'b1;
        wait_state("nom_run", P_RUN, 60);
        check_eq("nom_chan0", 32'(chan_rst), 32'(0));
        cycles(5);

        // Lock glitch during STABLE.
        do_reset();
        lock_i = 1'b1;
        wait_state("gl_stable", P_STAB, 40);
        cycles(3);
        lock_i = 1'b0;
        cycles(3);
        lock_i = 1'b1;
        wait_state("gl_run", P_RUN, 60);
        check_eq("gl_loss", 32'(loss_count), 32'(0));

        // Loss in RUN: three edges to all-reset.
        lock_i = 1'b0;
        cycles(2);
        check_eq("loss_ready2", 32'(ready), 32'(1));
        cycle();
        check_eq("loss_ready3", 32'(ready), 32'(0));
        check_eq("loss_chan3", 32'(chan_rst), 32'(3'b111));
        check_eq("loss_cnt", 32'(loss_count), 32'(1));
        cycles(5);

        // Timeouts to FAIL, then retry.
        do_reset();
        lock_i = 1'b0;
        wait_state("to_fail", P_FAIL, 100);
        check_eq("to_pllrst", 32'(pll_rst), 32'(1));
        cycles(4);
        retry_i = 1'b1;
        cycle();
        retry_i = 1'b0;
        check_eq("retry_fail", 32'(fail), 32'(0));
        check_eq("retry_state", 32'(state), 32'(P_PRST));
        cycles(6);

        // Loss counter saturation with recovery each time.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            lock_i = 1'b1;
            wait_state("sat_run", P_RUN, 60);
            lock_i = 1'b0;
            cycles(4);
        end
        check_eq("sat_loss", 32'(loss_count), 32'(LMAX));
        lock_i = 1'b1;
        wait_state("sat_recover", P_RUN, 60);

        // Reset in the middle of RELEASE.
        do_reset();
        lock_i = 1'b1;
        wait_state("mid_rel", P_REL, 60);
        rst_i = 1'b1;
        cycle();
        check_eq("mid_state", 32'(state), 32'(P_PRST));
        check_eq("mid_chan", 32'(chan_rst), 32'(3'b111));
        rst_i = 1'b0;

        // Random lock runs, stray retry pulses and occasional resets.
        for (int r = 0; r < 60; r++) begin
            int len;
            lock_i = ($urandom_range(0, 1) == 1);
            len = lock_i ? $urandom_range(1, 60) : $urandom_range(1, 80);
            for (int c = 0; c < len; c++) begin
                retry_i = ($urandom_range(0, 14) == 0);
                rst_i   = ($urandom_range(0, 299) == 0);
                cycle();
            end
        end
        rst_i   = 1'b0;
        retry_i = 1'b0;
        cycles(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
